// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) receive checker: self-synchronises, locks, counts errors, re-hunts on loss.
// Optional PRBS31_CHK_BITCNT_EN adds a 32-bit saturating count of bits checked while locked.
module prbs31_checker #(
    parameter int LOCK_COUNT  = 64,
    parameter int WINDOW      = 128,
    parameter int LOSS_THRESH = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_count,
    output logic             locked,
    output logic             err_pulse,
`ifdef PRBS31_CHK_BITCNT_EN
    output logic [31:0]      bit_count,
`endif
    output logic [CNT_W-1:0] err_count
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int EW = $clog2(LOSS_THRESH + 1);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [30:0]      h_q, h_d;
    logic [4:0]       fill_q, fill_d;
    logic [MW-1:0]    match_q, match_d;
    logic [WW-1:0]    win_cnt_q, win_cnt_d;
    logic [EW-1:0]    win_err_q, win_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             err_pulse_q, err_pulse_d;
    logic [31:0]      bit_count_q, bit_count_d;

    logic valid, pred, bit_err;

    assign valid   = din_valid & ena;
    assign pred    = h_q[30] ^ h_q[27];
    assign bit_err = din ^ pred;

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_count_d = err_count_q;
        bit_count_d = bit_count_q;
        err_pulse_d = 1'b0;
        if (valid) begin
            if (state_q == HUNT) begin
                h_d = {h_q[29:0], din};
                if (fill_q != 5'd31) begin
                    fill_d = fill_q + 5'd1;
                end else if (!bit_err && h_q != '0) begin
                    if (match_q == MW'(LOCK_COUNT - 1)) begin
                        state_d   = LOCKED;
                        match_d   = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end else begin
                    // an all-zero history predicts zeros forever, so it never counts as a match
                    match_d = '0;
                end
            end else begin
                // replica runs free on its own prediction so a bad bit cannot corrupt it
                h_d       = {h_q[29:0], pred};
                win_cnt_d = win_cnt_q + 1'b1;
                if (bit_count_q != '1) bit_count_d = bit_count_q + 32'd1;
                if (bit_err) begin
                    err_pulse_d = 1'b1;
                    win_err_d   = win_err_q + 1'b1;
                    if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
                end
                if (win_err_d == EW'(LOSS_THRESH)) begin
                    state_d   = HUNT;
                    fill_d    = '0;
                    match_d   = '0;
                    win_cnt_d = '0;
                    win_err_d = '0;
                end else if (win_cnt_d == WW'(WINDOW)) begin
                    win_cnt_d = '0;
                    win_err_d = '0;
                end
            end
        end
        if (clr_count) begin
            err_count_d = '0;
            bit_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            h_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
`ifdef PRBS31_CHK_BITCNT_EN
    assign bit_count = bit_count_q;
`else
    logic unused_bit_count;
    assign unused_bit_count = ^bit_count_q;
`endif
endmodule

// File: tb/tb_prbs31_checker.sv
// Bench for prbs31_checker: directed scenarios plus randomized traffic against a queue-based model.
module tb_prbs31_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, ena = 1'b0, din = 1'b0, din_valid = 1'b0, clr_count = 1'b0;
    logic locked, err_pulse, locked4, err_pulse4;
    logic [15:0] err_count;
    logic [3:0]  err_count4;
`ifdef PRBS31_CHK_BITCNT_EN
    logic [31:0] bit_count, bit_count4;
`endif

    prbs31_checker dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .din_valid(din_valid),
        .clr_count(clr_count), .locked(locked), .err_pulse(err_pulse),
`ifdef PRBS31_CHK_BITCNT_EN
        .bit_count(bit_count),
`endif
        .err_count(err_count));

    prbs31_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .din_valid(din_valid),
        .clr_count(clr_count), .locked(locked4), .err_pulse(err_pulse4),
`ifdef PRBS31_CHK_BITCNT_EN
        .bit_count(bit_count4),
`endif
        .err_count(err_count4));

    int checks = 0, errors = 0;
    bit chk_en = 1'b0;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: bit history as a queue (index 0 newest), counters as plain ints.
    bit     hist[$];
    bit     m_locked, m_pulse;
    int     m_cnt, m_cnt4, m_fill, m_match, m_win, m_werr;
    longint m_bits;

    function automatic void model_step(bit rst, bit valid, bit d, bit clr);
        bit p, nz, e;
        if (!rst) begin
            m_locked = 0; m_pulse = 0; m_cnt = 0; m_cnt4 = 0; m_bits = 0;
            m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
            hist.delete();
            repeat (31) hist.push_back(1'b0);
            return;
        end
        m_pulse = 0;
        if (valid) begin
            p = hist[30] ^ hist[27];
            if (!m_locked) begin
                if (m_fill == 31) begin
                    nz = 0;
                    foreach (hist[i]) if (hist[i]) nz = 1;
                    if (d == p && nz) begin
                        m_match++;
                        if (m_match == 64) begin
                            m_locked = 1; m_match = 0; m_win = 0; m_werr = 0;
                        end
                    end else m_match = 0;
                end else m_fill++;
                hist.push_front(d);
            end else begin
                e = (d != p);
                if (e) begin
                    m_pulse = 1; m_werr++;
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt4 < 15) m_cnt4++;
                end
                m_win++;
                if (m_bits < 64'hFFFF_FFFF) m_bits++;
                hist.push_front(p);
                if (m_werr >= 16) begin
                    m_locked = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
                end else if (m_win == 128) begin
                    m_win = 0; m_werr = 0;
                end
            end
            void'(hist.pop_back());
        end
        if (clr) begin m_cnt = 0; m_cnt4 = 0; m_bits = 0; end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("locked", locked, m_locked);
            check("err_pulse", err_pulse, m_pulse);
            check("err_count", err_count, m_cnt);
            check("locked4", locked4, m_locked);
            check("err_pulse4", err_pulse4, m_pulse);
            check("err_count4", err_count4, m_cnt4);
`ifdef PRBS31_CHK_BITCNT_EN
            check("bit_count", bit_count, m_bits);
            check("bit_count4", bit_count4, m_bits);
`endif
        end
    end

    // Stream source, seeded with 0x7FFFFFFF.
    bit [30:0] gs;
    function automatic bit gen_next();
        bit b;
        b  = gs[30] ^ gs[27];
        gs = {gs[29:0], b};
        return b;
    endfunction

    task automatic cyc(bit r, bit e, bit v, bit d, bit c);
        rst_n = r; ena = e; din_valid = v; din = d; clr_count = c;
        @(posedge clk);
        model_step(r, e & v, d, c);
        @(negedge clk);
    endtask

    task automatic send(bit inv);
        cyc(1, 1, 1, gen_next() ^ inv, 0);
    endtask

    task automatic send_n(int n);
        for (int i = 0; i < n; i++) send(0);
    endtask

    task automatic relock_check(string nm);
        for (int i = 1; i <= 95; i++) begin
            send(0);
            if (i == 94) check({nm, "_not_yet"}, locked, 0);
            if (i == 95) check({nm, "_locked"}, locked, 1);
        end
    endtask

    initial begin
        int vb, burst;
        bit e, v, inv, c, r;
        cyc(0, 0, 0, 0, 0);
        chk_en = 1;
        cyc(0, 1, 1, 1, 0);
        check("rst_locked", locked, 0);
        check("rst_count", err_count, 0);
        check("rst_pulse", err_pulse, 0);

        // clean lock and long clean run
        gs = 31'h7FFF_FFFF;
        relock_check("t1");
        send_n(10000 - 95);
        check("t1_count", err_count, 0);

        // single inverted bit
        send_n(499);
        send(1);
        check("t2_pulse", err_pulse, 1);
        check("t2_locked", locked, 1);
        send(0);
        check("t2_pulse_gone", err_pulse, 0);
        check("t2_count", err_count, 1);
        send_n(300);
        cyc(1, 1, 0, 0, 1);
        check("clr_count", err_count, 0);

        // error burst forces loss of lock, then relock
        for (int k = 1; k <= 20; k++) begin
            send(1);
            if (k == 15) check("t3_still_locked", locked, 1);
            if (k == 16) begin
                check("t3_lost", locked, 0);
                check("t3_count", err_count, 16);
            end
        end
        relock_check("t3_relock");
        check("t3_count_kept", err_count, 16);

        // all-zero stream must not lock
        cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < 1000; i++) cyc(1, 1, 1, 0, 0);
        check("t4_zero_locked", locked, 0);
        check("t4_zero_count", err_count, 0);

        // alternating valid
        cyc(0, 1, 1, 0, 0);
        gs = 31'h7FFF_FFFF;
        vb = 0;
        while (vb < 95) begin
            cyc(1, 1, 1, gen_next(), 0);
            vb++;
            if (vb == 94) check("t4_alt_not_yet", locked, 0);
            if (vb == 95) check("t4_alt_locked", locked, 1);
            cyc(1, 1, 0, 1'($urandom_range(1)), 0);
        end
        check("t4_alt_hold", locked, 1);

        // saturation of narrow counter, then clear on an errored bit
        for (int k = 0; k < 20; k++) begin
            send_n(200);
            send(1);
        end
        check("t5_sat4", err_count4, 15);
        check("t5_count16", err_count, 20);
        send_n(10);
        cyc(1, 1, 1, gen_next() ^ 1'b1, 1);
        check("t5_clr_count", err_count, 0);
        check("t5_clr_count4", err_count4, 0);
        check("t5_clr_pulse", err_pulse, 1);

        // reset while locked
        cyc(1, 1, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            send_n(150);
            send(1);
        end
        send_n(3);
        check("t6_count5", err_count, 5);
        cyc(0, 1, 0, 0, 0);
        check("t6_rst_locked", locked, 0);
        check("t6_rst_count", err_count, 0);
        check("t6_rst_pulse", err_pulse, 0);
        relock_check("t6_relock");

        // randomized traffic
        burst = 0;
        for (int i = 0; i < 5000; i++) begin
            e = ($urandom_range(7) != 0);
            v = ($urandom_range(3) != 0);
            c = ($urandom_range(499) == 0);
            r = ($urandom_range(2999) != 0);
            if (e && v) begin
                if (burst > 0) begin inv = 1; burst--; end
                else begin
                    if ($urandom_range(599) == 0) burst = 20;
                    inv = ($urandom_range(63) == 0);
                end
                cyc(r, e, v, gen_next() ^ inv, c);
            end else begin
                cyc(r, e, v, 1'($urandom_range(1)), c);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
- Receive-side partner of the PRBS31 generator tile (polynomial x^31 + x^28 + 1); consumes the generator's serial bit stream, e.g. looped back through pads.
- Self-synchronises to the incoming stream, declares lock, then counts bit errors against a free-running local replica.
- Detects loss of lock and re-hunts automatically.

Parameters:
- LOCK_COUNT, 64, consecutive correct predictions required in HUNT before lock.
- WINDOW, 128, valid bits per loss-of-lock observation window.
- LOSS_THRESH, 16, errors within one window that force return to HUNT.
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; synchronous and active-low, sampled on rising clk.
- ena  input  1  tile enable; when low, no state changes (all registers hold).
- din  input  1  received serial bit.
- din_valid  input  1  din is sampled on clk rising edges where din_valid=1 and ena=1.
- clr_count  input  1  synchronous clear of err_count.
- locked  output  1  1 while in LOCKED state.
- err_pulse  output  1  single-cycle pulse, one per errored bit while locked.
- err_count  output  CNT_W  saturating count of errors while locked.

Behaviour:
- Reset, on a clk edge with rst_n=0: all registers clear; locked=0, err_pulse=0, err_count=0, history=0, state=HUNT.
- History register h[30:0] holds past bits; h[0] is the newest. Predicted bit p = h[30] ^ h[27].
- A "valid bit" means din_valid & ena on that clk edge. Registers change only on valid bits, except reset and clr_count.
- State HUNT:
  - Each valid bit shifts din into h; fill counter increments, saturating at 31.
  - Once fill=31, each valid bit compares din with p:
    - Match with h!=0: increment match_cnt.
    - Mismatch, or h==0: match_cnt cleared. h==0 blocks false lock on an all-zero stream.
  - When match_cnt reaches LOCK_COUNT: move to LOCKED. locked=1 is visible the cycle after that valid bit.
- State LOCKED:
  - Each valid bit shifts p (not din) into h, so the local replica runs free and errors do not propagate.
  - din != p: err_pulse=1 in the next cycle, and err_count increments, saturating at 2^CNT_W-1.
  - Window: win_cnt counts valid bits and win_err counts errors. When win_cnt reaches WINDOW, both clear.
  - If win_err reaches LOSS_THRESH: move to HUNT on the same edge; locked=0 the next cycle. fill, match_cnt, win_cnt and win_err clear. err_count is retained.
  - Entering LOCKED clears win_cnt and win_err.
- err_pulse is registered. It is 0 on any cycle that does not follow an errored valid bit.
- clr_count=1: err_count becomes 0 on that edge. If an error occurs on the same edge, clear wins (result 0); err_pulse still fires.
- Latency:
  - din to err_pulse: 1 cycle.
  - Minimum lock time from reset with clean data: 31 + LOCK_COUNT valid bits.
- Invalid cycles (din_valid=0) are fully transparent: no shift, no counting.

Optional Feature:
- Macro: PRBS31_CHK_BITCNT_EN.
- When defined:
  - Adds output bit_count (32 bits): number of valid bits checked while LOCKED, saturating at 2^32-1.
  - Cleared by reset and by clr_count together with err_count.
  - Lets firmware compute BER = err_count / bit_count.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. Clean PRBS31 from seed 0x7FFFFFFF, din_valid=1 continuously -> locked rises exactly one cycle after valid bit 95 (31+64); err_count=0 and err_pulse never set after 10000 bits.
2. Clean locked stream with bit 500 after lock inverted -> exactly one err_pulse, one cycle later; err_count=1; locked stays 1.
3. Locked stream, then 20 consecutive inverted bits -> locked drops the cycle after the 16th error; err_count=16. Afterwards, clean data relocks after 95 further valid bits with err_count still 16.
4. 1000 zero bits after reset -> locked stays 0; err_count=0. Alternating din_valid 1/0 with clean data -> lock after 95 valid bits (190 cycles).
5. CNT_W=4, 20 isolated errors spaced more than WINDOW apart -> err_count saturates at 15. Then clr_count asserted on an errored bit -> err_count=0, err_pulse=1.
6. rst_n=0 for one cycle while locked with err_count=5 -> next cycle locked=0, err_count=0, err_pulse=0. The full 95-bit relock is required.
